// File: rtl/ps2_keyboard_rx_if.sv
// Keyboard-side bundle: raw PS/2 lines in, decoded byte stream and held keycode out.
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       extended;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  keycode, extended, byte_valid, byte_data, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output keycode, extended, byte_valid, byte_data, frame_err
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronize and deglitch the raw lines, frame 11-bit words,
// and track make/break codes into a held keycode for the movement logic downstream.
module ps2_keyboard_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input logic              clk,
   input logic              rst,
   ps2_keyboard_rx_if.slave bus
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic [FW-1:0] filt_cnt;
   logic          clk_filt;
   logic          fall;

   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_ok, par_ok_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          byte_valid, byte_valid_n;
   logic [7:0]    byte_data, byte_data_n;
   logic          frame_err, frame_err_n;
   logic [7:0]    keycode, keycode_n;
   logic          extended, extended_n;
   logic          ext_pend, ext_pend_n;
   logic          brk_pend, brk_pend_n;
   logic          accept, discard;

   // The filtered level follows the synchronized clock only after FILTER_LEN
   // consecutive samples disagree with it; fall fires as the level drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         filt_cnt <= '0;
         clk_filt <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_s1 <= bus.ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.ps2_data;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
            fall     <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_ok     <= 1'b0;
         tcnt       <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
         keycode    <= '0;
         extended   <= 1'b0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         par_ok     <= par_ok_n;
         tcnt       <= tcnt_n;
         byte_valid <= byte_valid_n;
         byte_data  <= byte_data_n;
         frame_err  <= frame_err_n;
         keycode    <= keycode_n;
         extended   <= extended_n;
         ext_pend   <= ext_pend_n;
         brk_pend   <= brk_pend_n;
      end
   end

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shreg_n      = shreg;
      par_ok_n     = par_ok;
      byte_valid_n = 1'b0;
      byte_data_n  = byte_data;
      frame_err_n  = 1'b0;
      keycode_n    = keycode;
      extended_n   = extended;
      ext_pend_n   = ext_pend;
      brk_pend_n   = brk_pend;
      accept       = 1'b0;
      discard      = 1'b0;

      if (fall)
         tcnt_n = '0;
      else if (tcnt == TW'(TIMEOUT_CYCLES))
         tcnt_n = tcnt;
      else
         tcnt_n = tcnt + TW'(1);

      if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end else begin
                  discard = 1'b1;
               end
            end
            DATA: begin
               shreg_n   = {dat_s2, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_n = PARITY;
            end
            PARITY: begin
               par_ok_n = ^{shreg, dat_s2};
               state_n  = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_s2 && par_ok)
                  accept = 1'b1;
               else
                  discard = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
         state_n = IDLE;
         discard = 1'b1;
      end

      if (accept) begin
         byte_valid_n = 1'b1;
         byte_data_n  = shreg;
         if (shreg == 8'hE0) begin
            ext_pend_n = 1'b1;
         end else if (shreg == 8'hF0) begin
            brk_pend_n = 1'b1;
         end else begin
            if (!(shreg inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF})) begin
               if (!brk_pend) begin
                  keycode_n  = shreg;
                  extended_n = ext_pend;
               end else if (shreg == keycode && ext_pend == extended) begin
                  keycode_n  = '0;
                  extended_n = 1'b0;
               end
            end
            ext_pend_n = 1'b0;
            brk_pend_n = 1'b0;
         end
      end

      if (discard) begin
         frame_err_n = 1'b1;
         ext_pend_n  = 1'b0;
         brk_pend_n  = 1'b0;
      end
   end

   assign bus.keycode    = keycode;
   assign bus.extended   = extended;
   assign bus.byte_valid = byte_valid;
   assign bus.byte_data  = byte_data;
   assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench: each sent frame pushes its expected outcome; a monitor pops on
// every byte_valid/frame_err pulse and compares byte, keycode and extended.
module tb_ps2_keyboard_rx;

   localparam int unsigned TMO = 500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_keyboard_rx_if bus ();

   ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      logic [7:0] kc;
      logic       ext;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Device drives data while the clock is high; each bit is 80 clk cycles long.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int unsigned nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int unsigned i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         cyc(20);
         bus.ps2_clk = 1'b0;
         cyc(40);
         bus.ps2_clk = 1'b1;
         cyc(20);
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input logic [7:0] kc, input logic ext);
      sb.push_back('{is_err: 1'b0, data: b, kc: kc, ext: ext});
      send_bits(b, 1'b0, 11);
      cyc(100);
   endtask

   task automatic bad_frame(input logic [7:0] b, input logic [7:0] kc, input logic ext);
      sb.push_back('{is_err: 1'b1, data: 8'h00, kc: kc, ext: ext});
      send_bits(b, 1'b1, 11);
      cyc(100);
   endtask

   always @(negedge clk) begin
      if (mon_en && (bus.byte_valid || bus.frame_err)) begin
         if (bus.byte_valid && bus.frame_err)
            chk("strobes_exclusive", 32'(bus.byte_valid & bus.frame_err), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, bus.byte_valid, bus.frame_err}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("event_kind", 32'(bus.frame_err), 32'(mon_e.is_err));
            if (!mon_e.is_err)
               chk("byte_data", 32'(bus.byte_data), 32'(mon_e.data));
            chk("keycode", 32'(bus.keycode), 32'(mon_e.kc));
            chk("extended", 32'(bus.extended), 32'(mon_e.ext));
         end
      end
   end

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst = 1'b1;
      cyc(5);
      chk("rst_keycode", 32'(bus.keycode), 32'd0);
      chk("rst_extended", 32'(bus.extended), 32'd0);
      chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("rst_byte_data", 32'(bus.byte_data), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      cyc(50);

      // extended make then extended break
      frame(8'hE0, 8'h00, 1'b0);
      frame(8'h75, 8'h75, 1'b1);
      frame(8'hE0, 8'h75, 1'b1);
      frame(8'hF0, 8'h75, 1'b1);
      frame(8'h75, 8'h00, 1'b0);

      // parity error also cancels the pending break prefix
      frame(8'hF0, 8'h00, 1'b0);
      bad_frame(8'h72, 8'h00, 1'b0);
      frame(8'h72, 8'h72, 1'b0);
      frame(8'hF0, 8'h72, 1'b0);
      frame(8'h72, 8'h00, 1'b0);

      // rollover
      frame(8'h74, 8'h74, 1'b0);
      frame(8'h6B, 8'h6B, 1'b0);
      frame(8'hF0, 8'h6B, 1'b0);
      frame(8'h74, 8'h6B, 1'b0);

      // timeout on a partial frame
      sb.push_back('{is_err: 1'b1, data: 8'h00, kc: 8'h6B, ext: 1'b0});
      send_bits(8'h6B, 1'b0, 5);
      cyc(TMO + 10);
      frame(8'h6B, 8'h6B, 1'b0);
      frame(8'hF0, 8'h6B, 1'b0);
      frame(8'h6B, 8'h00, 1'b0);

      // glitches while idle, then BAT completion code
      for (int i = 0; i < 3; i++) begin
         bus.ps2_clk = 1'b0;
         cyc(3);
         bus.ps2_clk = 1'b1;
         cyc(30);
      end
      frame(8'hAA, 8'h00, 1'b0);

      // break with mismatched extended flag leaves keycode alone
      frame(8'h75, 8'h75, 1'b0);
      frame(8'hE0, 8'h75, 1'b0);
      frame(8'hF0, 8'h75, 1'b0);
      frame(8'h75, 8'h75, 1'b0);

      // reset after the 5th data bit
      frame(8'h74, 8'h74, 1'b0);
      send_bits(8'h75, 1'b0, 6);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("midrst_keycode", 32'(bus.keycode), 32'd0);
      chk("midrst_extended", 32'(bus.extended), 32'd0);
      chk("midrst_byte_valid", 32'(bus.byte_valid), 32'd0);
      chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("midrst_byte_data", 32'(bus.byte_data), 32'd0);
      cyc(TMO + 50);
      frame(8'h75, 8'h75, 1'b0);

      cyc(50);
      chk("final_keycode", 32'(bus.keycode), 32'h75);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
